// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register bank.
//  - DEFAULT_WIDTH / DEFAULT_DEPTH: default bank geometry
//  - regfile_clog2: address-width helper, usable in parameter context
//  - rv_set_word: reset-vector builder; replaces one word of a packed
//    DEPTH*WIDTH reset vector (default geometry) with a constant
//  - DEFAULT_RESET_VALS: example bank reset image with the status word
//    (index STATUS_IDX) resetting to STATUS_RST
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  localparam int unsigned               STATUS_IDX = 1;
  localparam logic [DEFAULT_WIDTH-1:0]  STATUS_RST = 16'h02E1;

  function automatic int unsigned regfile_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [DEFAULT_DEPTH*DEFAULT_WIDTH-1:0] rv_set_word(
    input logic [DEFAULT_DEPTH*DEFAULT_WIDTH-1:0] base,
    input int unsigned                            idx,
    input logic [DEFAULT_WIDTH-1:0]               val
  );
    logic [DEFAULT_DEPTH*DEFAULT_WIDTH-1:0] r;
    r = base;
    r[idx*DEFAULT_WIDTH +: DEFAULT_WIDTH] = val;
    return r;
  endfunction

  localparam logic [DEFAULT_DEPTH*DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALS =
    rv_set_word('0, STATUS_IDX, STATUS_RST);

endpackage

// File: rtl/reg_word_init.sv
// reg_word_init: one WIDTH-bit storage word with its own reset constant.
//  clk       in  clock, rising edge
//  Clear     in  asynchronous reset, active-high, loads RST_VAL
//  load_i    in  update the word on the next edge
//  sel_alt_i in  load source select: 0 = wdata_i, 1 = alt_i
//  wdata_i   in  write-port data
//  alt_i     in  alternate data (shadow or live copy)
//  q_o       out current word contents
module reg_word_init
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             load_i,
  input  logic             sel_alt_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] alt_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = sel_alt_i ? alt_i : wdata_i;
    end
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      word_q <= RST_VAL;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file_shadow.sv
// reg_file_shadow: DEPTH x WIDTH register bank, two combinational read
// ports, one synchronous write port, and a one-deep shadow image for
// single-cycle save / restore / swap of the whole bank.
//  clk        in  clock, rising edge
//  Clear      in  asynchronous reset, active-high
//  we/waddr/wdata       write port
//  raddr_a/rdata_a      read port A (combinational)
//  raddr_b/rdata_b      read port B (combinational)
//  save       in  copy live bank into shadow
//  restore    in  copy shadow into live bank (only when shadow_vld)
//  shadow_vld out shadow holds a saved image
// Build option: REGFILE_BYPASS_EN forwards wdata to a read port whose
// address matches a legal write target in the same cycle.
module reg_file_shadow
  import regfile_pkg::*;
#(
  parameter int unsigned             WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned             DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned             AW         = regfile_clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0]  RESET_VALS = '0,
  parameter bit                      ZERO_REG   = 1'b1
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             save,
  input  logic             restore,
  output logic             shadow_vld
);

  logic [WIDTH-1:0] live_q   [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic             shadow_vld_q, shadow_vld_d;
  logic             restore_ok;
  logic             wr_legal;

  assign restore_ok = restore && shadow_vld_q;
  assign wr_legal   = we && (32'(waddr) < DEPTH) && !(ZERO_REG && (waddr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam bit               IS_ZERO = ZERO_REG && (i == 0);
    localparam logic [WIDTH-1:0] RST     = IS_ZERO ? '0 : RESET_VALS[i*WIDTH +: WIDTH];

    logic live_load;

    // A valid restore takes the whole live bank and drops the write.
    assign live_load = !IS_ZERO && (restore_ok || (wr_legal && (waddr == AW'(i))));

    reg_word_init #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST)
    ) u_live (
      .clk       (clk),
      .Clear     (Clear),
      .load_i    (live_load),
      .sel_alt_i (restore_ok),
      .wdata_i   (wdata),
      .alt_i     (shadow_q[i]),
      .q_o       (live_q[i])
    );

    // Shadow captures pre-edge live contents on save, which also covers
    // the swap case (save together with a valid restore).
    reg_word_init #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST)
    ) u_shadow (
      .clk       (clk),
      .Clear     (Clear),
      .load_i    (save),
      .sel_alt_i (1'b1),
      .wdata_i   ('0),
      .alt_i     (live_q[i]),
      .q_o       (shadow_q[i])
    );
  end

  always_comb begin
    shadow_vld_d = shadow_vld_q;
    if (restore_ok && !save) begin
      shadow_vld_d = 1'b0;
    end else if (save) begin
      shadow_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      shadow_vld_q <= 1'b0;
    end else begin
      shadow_vld_q <= shadow_vld_d;
    end
  end

  assign shadow_vld = shadow_vld_q;

  always_comb begin
    rdata_a = '0;
    if ((32'(raddr_a) < DEPTH) && !(ZERO_REG && (raddr_a == '0))) begin
      rdata_a = live_q[raddr_a];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_legal && !restore_ok && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
`endif
  end

  always_comb begin
    rdata_b = '0;
    if ((32'(raddr_b) < DEPTH) && !(ZERO_REG && (raddr_b == '0))) begin
      rdata_b = live_q[raddr_b];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_legal && !restore_ok && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_shadow.sv
module tb_reg_file_shadow;
  import regfile_pkg::*;

  localparam logic [127:0] RV  = DEFAULT_RESET_VALS;
  localparam logic [95:0]  RV6 = 96'h0055;

  logic        clk = 1'b0;
  bit          clk_en = 1'b0;
  logic        Clear;
  logic        we, save, restore;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata, rdata_a, rdata_b;
  logic        shadow_vld;

  logic        we6;
  logic [2:0]  waddr6, raddr6_a, raddr6_b;
  logic [15:0] wdata6, rdata6_a, rdata6_b;
  logic        vld6;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] live_m [8];
  logic [15:0] shad_m [8];
  bit          vld_m;
  logic [15:0] m6 [6];

  always #5 if (clk_en) clk = ~clk;

  reg_file_shadow #(
    .WIDTH(16), .DEPTH(8), .RESET_VALS(RV), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .Clear(Clear), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .save(save), .restore(restore), .shadow_vld(shadow_vld)
  );

  reg_file_shadow #(
    .WIDTH(16), .DEPTH(6), .RESET_VALS(RV6), .ZERO_REG(1'b0)
  ) dut6 (
    .clk(clk), .Clear(Clear), .we(we6), .waddr(waddr6), .wdata(wdata6),
    .raddr_a(raddr6_a), .rdata_a(rdata6_a), .raddr_b(raddr6_b), .rdata_b(rdata6_b),
    .save(1'b0), .restore(1'b0), .shadow_vld(vld6)
  );

  function automatic void model_reset();
    logic [127:0] v;
    logic [95:0]  v6;
    v = RV;
    v6 = RV6;
    for (int i = 0; i < 8; i++) begin
      live_m[i] = (i == 0) ? 16'h0 : v[i*16 +: 16];
      shad_m[i] = live_m[i];
    end
    for (int i = 0; i < 6; i++) m6[i] = v6[i*16 +: 16];
    vld_m = 1'b0;
  endfunction

  function automatic void model_edge(bit w, logic [2:0] a, logic [15:0] d, bit s, bit r);
    logic [15:0] old_live [8];
    old_live = live_m;
    if (r && vld_m) begin
      live_m = shad_m;
      live_m[0] = 16'h0;
      if (s) shad_m = old_live;
      else vld_m = 1'b0;
    end else begin
      if (s) begin
        shad_m = old_live;
        vld_m = 1'b1;
      end
      if (w && a != 3'd0) live_m[a] = d;
    end
  endfunction

  function automatic logic [15:0] m_read(logic [2:0] a);
    return (a == 3'd0) ? 16'h0 : live_m[a];
  endfunction

  // Expected combinational read given the inputs currently applied.
  function automatic logic [15:0] m_read_now(logic [2:0] a, bit w, logic [2:0] wa,
                                             logic [15:0] d, bit r);
    logic [15:0] v;
    v = m_read(a);
`ifdef REGFILE_BYPASS_EN
    if (w && wa != 3'd0 && !(r && vld_m) && a == wa) v = d;
`endif
    return v;
  endfunction

  task automatic step(input bit w, input logic [2:0] a, input logic [15:0] d,
                      input bit s, input bit r);
    we = w; waddr = a; wdata = d; save = s; restore = r;
    @(posedge clk);
    #1;
    model_edge(w, a, d, s, r);
    we = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  task automatic step6(input logic [2:0] a, input logic [15:0] d);
    we6 = 1'b1; waddr6 = a; wdata6 = d;
    @(posedge clk);
    #1;
    if (a < 3'd6) m6[a] = d;
    we6 = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    #2;
    raddr_a = 3'd1; raddr_b = 3'd3;
    #1;
    model_reset();
    checks++; if (rdata_a !== 16'h02E1) begin errors++; $display("FAIL reset_r1: got %h exp %h", rdata_a, 16'h02E1); end
    checks++; if (rdata_b !== 16'h0000) begin errors++; $display("FAIL reset_r3: got %h exp %h", rdata_b, 16'h0000); end
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", shadow_vld); end
    raddr6_a = 3'd0;
    #1;
    checks++; if (rdata6_a !== 16'h0055) begin errors++; $display("FAIL reset6_r0: got %h exp %h", rdata6_a, 16'h0055); end
    Clear = 1'b0;
    #1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    step(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0);
    raddr_b = 3'd3;
    #1;
    checks++; if (rdata_b !== 16'hBEEF) begin errors++; $display("FAIL wr_r3: got %h exp %h", rdata_b, 16'hBEEF); end
    step(1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0);
    raddr_a = 3'd0;
    #1;
    checks++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL wr_r0: got %h exp %h", rdata_a, 16'h0000); end
  endtask

  task automatic test_save_restore();
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    checks++; if (shadow_vld !== 1'b1) begin errors++; $display("FAIL sr_vld_set: got %b exp 1", shadow_vld); end
    step(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    raddr_a = 3'd3;
    #1;
    checks++; if (rdata_a !== 16'h1234) begin errors++; $display("FAIL sr_live: got %h exp %h", rdata_a, 16'h1234); end
    step(1'b1, 3'd3, 16'h4444, 1'b0, 1'b1);
    #1;
    checks++; if (rdata_a !== 16'hBEEF) begin errors++; $display("FAIL sr_restore: got %h exp %h", rdata_a, 16'hBEEF); end
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL sr_vld_clr: got %b exp 0", shadow_vld); end
    step(1'b1, 3'd3, 16'h7777, 1'b0, 1'b1);
    #1;
    checks++; if (rdata_a !== 16'h7777) begin errors++; $display("FAIL sr_reissue: got %h exp %h", rdata_a, 16'h7777); end
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL sr_reissue_vld: got %b exp 0", shadow_vld); end
  endtask

  task automatic test_swap();
    step(1'b1, 3'd2, 16'h0011, 1'b0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 3'd2, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 3'd2, 16'h9999, 1'b1, 1'b1);
    raddr_a = 3'd2;
    #1;
    checks++; if (rdata_a !== 16'h0011) begin errors++; $display("FAIL swap_live: got %h exp %h", rdata_a, 16'h0011); end
    checks++; if (shadow_vld !== 1'b1) begin errors++; $display("FAIL swap_vld: got %b exp 1", shadow_vld); end
    step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    #1;
    checks++; if (rdata_a !== 16'h0022) begin errors++; $display("FAIL swap_shadow: got %h exp %h", rdata_a, 16'h0022); end
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL swap_vld_clr: got %b exp 0", shadow_vld); end
  endtask

  task automatic test_save_write();
    step(1'b1, 3'd4, 16'h0005, 1'b0, 1'b0);
    step(1'b1, 3'd4, 16'h0009, 1'b1, 1'b0);
    raddr_b = 3'd4;
    #1;
    checks++; if (rdata_b !== 16'h0009) begin errors++; $display("FAIL sw_live: got %h exp %h", rdata_b, 16'h0009); end
    step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    #1;
    checks++; if (rdata_b !== 16'h0005) begin errors++; $display("FAIL sw_restore: got %h exp %h", rdata_b, 16'h0005); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_v;
    step(1'b1, 3'd6, 16'h1111, 1'b0, 1'b0);
    we = 1'b1; waddr = 3'd6; wdata = 16'hA5A5; raddr_a = 3'd6;
`ifdef REGFILE_BYPASS_EN
    exp_v = 16'hA5A5;
`else
    exp_v = 16'h1111;
`endif
    #1;
    checks++; if (rdata_a !== exp_v) begin errors++; $display("FAIL byp_same_cycle: got %h exp %h", rdata_a, exp_v); end
    waddr = 3'd0; raddr_a = 3'd0;
    #1;
    checks++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL byp_r0: got %h exp %h", rdata_a, 16'h0000); end
    we = 1'b0;
    step(1'b1, 3'd6, 16'hA5A5, 1'b0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    // Valid restore suppresses forwarding: old live value shows.
    we = 1'b1; waddr = 3'd6; wdata = 16'h5A5A; restore = 1'b1; raddr_a = 3'd6;
    #1;
    checks++; if (rdata_a !== 16'hA5A5) begin errors++; $display("FAIL byp_restore_supp: got %h exp %h", rdata_a, 16'hA5A5); end
    step(1'b1, 3'd6, 16'h5A5A, 1'b0, 1'b1);
    #1;
    checks++; if (rdata_a !== 16'hA5A5) begin errors++; $display("FAIL byp_restore_edge: got %h exp %h", rdata_a, 16'hA5A5); end
  endtask

  task automatic test_out_of_range();
    raddr6_a = 3'd7; raddr6_b = 3'd6;
    #1;
    checks++; if (rdata6_a !== 16'h0000) begin errors++; $display("FAIL oor_rd7: got %h exp 0000", rdata6_a); end
    step6(3'd7, 16'hFFFF);
    step6(3'd6, 16'hEEEE);
    step6(3'd0, 16'h1234);
    step6(3'd5, 16'hABCD);
    #1;
    checks++; if (rdata6_a !== 16'h0000) begin errors++; $display("FAIL oor_wr7: got %h exp 0000", rdata6_a); end
    checks++; if (rdata6_b !== 16'h0000) begin errors++; $display("FAIL oor_wr6: got %h exp 0000", rdata6_b); end
    raddr6_a = 3'd0; raddr6_b = 3'd5;
    #1;
    checks++; if (rdata6_a !== m6[0]) begin errors++; $display("FAIL d6_r0: got %h exp %h", rdata6_a, m6[0]); end
    checks++; if (rdata6_b !== 16'hABCD) begin errors++; $display("FAIL d6_r5: got %h exp %h", rdata6_b, 16'hABCD); end
    we6 = 1'b1; waddr6 = 3'd7; wdata6 = 16'hCAFE; raddr6_a = 3'd7;
    #1;
    checks++; if (rdata6_a !== 16'h0000) begin errors++; $display("FAIL oor_bypass7: got %h exp 0000", rdata6_a); end
    we6 = 1'b0;
  endtask

  task automatic test_clear_abort();
    step(1'b1, 3'd5, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    we = 1'b1; waddr = 3'd5; wdata = 16'hAAAA; save = 1'b1; restore = 1'b1;
    raddr_a = 3'd5; raddr_b = 3'd1;
    #2;
    Clear = 1'b1;
    #1;
    model_reset();
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL clr_async_vld: got %b exp 0", shadow_vld); end
    @(posedge clk);
    #1;
    Clear = 1'b0;
    we = 1'b0; save = 1'b0; restore = 1'b0;
    #1;
    checks++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL clr_r5: got %h exp 0000", rdata_a); end
    checks++; if (rdata_b !== 16'h02E1) begin errors++; $display("FAIL clr_r1: got %h exp %h", rdata_b, 16'h02E1); end
    checks++; if (shadow_vld !== 1'b0) begin errors++; $display("FAIL clr_vld: got %b exp 0", shadow_vld); end
  endtask

  task automatic test_random();
    bit          w, s, r;
    logic [2:0]  a, ra, rb;
    logic [15:0] d, ea, eb;
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      s  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 4) == 0);
      ra = 3'($urandom_range(0, 7));
      rb = (n % 3 == 0) ? a : 3'($urandom_range(0, 7));
      we = w; waddr = a; wdata = d; save = s; restore = r;
      raddr_a = ra; raddr_b = rb;
      #1;
      ea = m_read_now(ra, w, a, d, r);
      eb = m_read_now(rb, w, a, d, r);
      checks++; if (rdata_a !== ea) begin errors++; $display("FAIL rnd_pre_a[%0d]: got %h exp %h", n, rdata_a, ea); end
      checks++; if (rdata_b !== eb) begin errors++; $display("FAIL rnd_pre_b[%0d]: got %h exp %h", n, rdata_b, eb); end
      @(posedge clk);
      #1;
      model_edge(w, a, d, s, r);
      we = 1'b0; save = 1'b0; restore = 1'b0;
      #1;
      checks++; if (shadow_vld !== vld_m) begin errors++; $display("FAIL rnd_vld[%0d]: got %b exp %b", n, shadow_vld, vld_m); end
      checks++; if (rdata_a !== m_read(ra)) begin errors++; $display("FAIL rnd_post_a[%0d]: got %h exp %h", n, rdata_a, m_read(ra)); end
    end
  endtask

  initial begin
    Clear = 1'b0; we = 1'b0; save = 1'b0; restore = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    we6 = 1'b0; waddr6 = '0; wdata6 = '0; raddr6_a = '0; raddr6_b = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_save_restore();
    test_swap();
    test_save_write();
    test_bypass();
    test_out_of_range();
    test_clear_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
